instr_fetch_unit: RTL

Instruction fetch front end that drives the word address of the synchronous 16-bit instruction memory and captures the returned words. Fetched words enter a small in-order buffer together with their PC and are handed to decode over a valid/ready handshake. The block sits between the program counter logic and the decoder, and absorbs decode stalls and branch redirects.

---
 rtl/instr_fetch_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch front end for a synchronous 16-bit instruction memory. The PC
// register drives the memory address directly. Returned words are pushed,
// together with their PC, into a small in-order buffer. The buffer head is
// handed to decode over a valid/ready handshake. The block absorbs decode
// stalls and branch redirects.
//
// When the buffer is empty, the word returning from memory is presented
// straight to decode. This gives the first instruction one cycle of latency
// after its address is issued. If decode accepts it in that cycle, the word
// never enters the buffer. The in-flight slot therefore counts toward
// occupancy.
//
// Parameters
//   ADDR_W    PC / memory word-address width
//   DATA_W    instruction width
//   RESET_PC  PC loaded on reset
//   DEPTH     fetch buffer entries (power of two, >= 2)
//
// Ports
//   clk          in   single rising-edge clock
//   reset        in   asynchronous active-high reset
//   mem_addr     out  instruction memory word address (the PC register)
//   mem_data     in   memory read data, valid the cycle after the address
//   instr        out  instruction at the buffer head
//   instr_pc     out  PC of instr
//   instr_valid  out  head is valid
//   instr_ready  in   decode accepts the head
//   redirect     in   flush and restart at redirect_pc
//   redirect_pc  in   restart target
//   halted       out  fetch stopped on an all-ones word
//
// Configuration macro
//   IFETCH_HALT_EN  When this macro is defined, a captured all-ones word
//                   stops fetching and raises halted. When it is undefined,
//                   halted is constantly 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              halted_q, halted_d;

   logic [DATA_W-1:0] bufData_q [DEPTH];
   logic [ADDR_W-1:0] bufPc_q   [DEPTH];

   logic              bufEmpty;
   logic              headIsBypass;
   logic              pop;
   logic              bufPop;
   logic              push;
   logic              issue;
   logic              haltDetect;
   logic [OCC_W-1:0]  occupancyNext;

   // Head selection. A non-empty buffer presents its oldest entry. An empty
   // buffer presents the word returning from memory this cycle, if one is
   // in flight. Otherwise the outputs are zero.
   always_comb begin
      bufEmpty     = (count_q == '0);
      headIsBypass = bufEmpty && inflight_q;
      instr_valid  = !bufEmpty || inflight_q;
      instr        = '0;
      instr_pc     = '0;
      if (!bufEmpty) begin
         instr    = bufData_q[head_q];
         instr_pc = bufPc_q[head_q];
      end else if (inflight_q) begin
         instr    = mem_data;
         instr_pc = inflightPc_q;
      end
   end

   // Halt detection looks at the word being captured this cycle. A redirect
   // in the same cycle wins and discards that word. Without the macro,
   // nothing is ever treated as a halt.
`ifdef IFETCH_HALT_EN
   always_comb begin
      haltDetect = inflight_q && (mem_data == {DATA_W{1'b1}}) && !redirect;
   end
`else
   always_comb begin
      haltDetect = 1'b0;
   end
`endif

   // Issue and buffer-movement decisions.
   // - Occupancy is the buffered words plus the in-flight word. It must stay
   //   within DEPTH after this cycle's pop and a possible new issue.
   // - A captured halt word suppresses the issue at the same edge, so no
   //   word follows it.
   // - The in-flight word is pushed unless decode took it directly from
   //   the bypass path.
   always_comb begin
      pop           = instr_valid && instr_ready;
      bufPop        = pop && !bufEmpty;
      occupancyNext = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
      issue         = !redirect && !halted_q && !haltDetect &&
                      (occupancyNext < OCC_W'(DEPTH));
      push          = inflight_q && !redirect && !(headIsBypass && pop);
   end

   // PC and in-flight tracking. Redirect reloads the PC and drops whatever
   // is in flight. An issue advances the PC, wrapping naturally at the
   // address width, and remembers the address just sent to memory.
   always_comb begin
      pc_d         = pc_q;
      inflight_d   = 1'b0;
      inflightPc_d = inflightPc_q;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d         = pc_q + ADDR_W'(1);
         inflight_d   = 1'b1;
         inflightPc_d = pc_q;
      end
   end

   // Buffer pointers, count and halt flag. Redirect empties the buffer and
   // releases a halt. Otherwise, push and pop move independently, so a
   // simultaneous push and pop leave the count unchanged.
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      halted_d = halted_q;
      if (redirect) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         halted_d = 1'b0;
      end else begin
         if (push) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (bufPop) begin
            head_d = head_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(bufPop);
         if (haltDetect) begin
            halted_d = 1'b1;
         end
      end
   end

   // Control state register. Reset returns everything to the start-up
   // state at once, and any word in flight is forgotten.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         inflight_q   <= 1'b0;
         inflightPc_q <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         halted_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         inflight_q   <= inflight_d;
         inflightPc_q <= inflightPc_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         halted_q     <= halted_d;
      end
   end

   // Buffer storage. It needs no reset, because entries are only read once
   // the count says they were written.
   always_ff @(posedge clk) begin
      if (push) begin
         bufData_q[tail_q] <= mem_data;
         bufPc_q[tail_q]   <= inflightPc_q;
      end
   end

   always_comb begin
      mem_addr = pc_q;
      halted   = halted_q;
   end

endmodule
